// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared constants, FSM states and month-length helper for tick_to_calendar
package calendar_pkg;

   localparam int EPOCH_YEAR    = 1970;
   localparam int EPOCH_WEEKDAY = 4;
   localparam int SECS_PER_DAY  = 86400;
   localparam int MAX_DAYS      = 2932896;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DIV_CS,
      ST_DIV_DAY,
      ST_RANGE,
      ST_DIV_WK,
      ST_HMS,
      ST_YEAR,
      ST_MONTH,
      ST_DONE
   } calState;

   // Days in a month (1..12); February depends on the leap flag.
   function automatic logic [4:0] monthLen(input logic [3:0] month, input logic leap);
      case (month)
         4'd2:                    monthLen = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: monthLen = 5'd30;
         default:                 monthLen = 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract divider, 64-bit dividend, 17-bit divisor, 64 cycles
module seq_divider (
   input  logic        clockSignal,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] dividend,
   input  logic [16:0] divisor,
   output logic        done,
   output logic [63:0] quotient,
   output logic [16:0] remainder
);

   logic        running;
   logic [5:0]  stepCount;
   logic [17:0] trial;
   logic [17:0] diff;

   // Partial remainder shifted left with the next dividend bit, and its trial difference
   always_comb begin
      trial = {remainder, quotient[63]};
      diff  = trial - {1'b0, divisor};
   end

   // One quotient bit per cycle; the quotient register doubles as the dividend shifter
   always_ff @(posedge clockSignal) begin
      if (reset) begin
         running   <= 1'b0;
         done      <= 1'b0;
         stepCount <= 6'd0;
         quotient  <= 64'd0;
         remainder <= 17'd0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quotient  <= dividend;
            remainder <= 17'd0;
            stepCount <= 6'd0;
            running   <= 1'b1;
         end else if (running) begin
            if (trial >= {1'b0, divisor}) begin
               remainder <= diff[16:0];
               quotient  <= {quotient[62:0], 1'b1};
            end else begin
               remainder <= trial[16:0];
               quotient  <= {quotient[62:0], 1'b0};
            end
            stepCount <= stepCount + 6'd1;
            if (stepCount == 6'd63) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tick_to_calendar.sv
// rtl/tick_to_calendar.sv - iterative 100 Hz tick count to calendar/time-of-day converter
module tick_to_calendar
   import calendar_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int MAX_YEAR      = 9999
) (
   input  logic        clockSignal,
   input  logic        reset,
   input  logic [63:0] tickCount,
   input  logic        convertStart,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [6:0]  centiseconds,
   output logic [5:0]  seconds,
   output logic [5:0]  minutes,
   output logic [4:0]  hours,
   output logic [4:0]  dayOfMonth,
   output logic [3:0]  month,
   output logic [13:0] year,
   output logic [2:0]  weekday
);

   localparam logic [16:0] CS_DIVISOR  = 17'(TICKS_PER_SEC);
   localparam logic [16:0] DAY_DIVISOR = 17'(SECS_PER_DAY);
   localparam logic [16:0] WK_DIVISOR  = 17'd7;
   localparam logic [63:0] DAY_LIMIT   = 64'(MAX_DAYS);

   calState     state, nextState;

   logic [63:0] tickReg;
   logic [63:0] secsReg;
   logic [63:0] dayReg;
   logic [16:0] secOfDay;
   logic [6:0]  csReg;
   logic [4:0]  hourReg;
   logic [5:0]  minReg;
   logic [13:0] yearReg;
   logic [1:0]  mod4;
   logic [6:0]  mod100;
   logic [8:0]  mod400;
   logic [3:0]  monthReg;
   logic [2:0]  wdReg;
   logic        divIssued;

   logic        divStart;
   logic [63:0] divDividend;
   logic [16:0] divDivisor;
   logic        divDone;
   logic [63:0] divQuot;
   logic [16:0] divRem;

   logic        leap;
   logic [8:0]  yearLen;
   logic [4:0]  curMonthLen;
   logic [3:0]  wdSum;

   seq_divider divider (
      .clockSignal (clockSignal),
      .reset       (reset),
      .start       (divStart),
      .dividend    (divDividend),
      .divisor     (divDivisor),
      .done        (divDone),
      .quotient    (divQuot),
      .remainder   (divRem)
   );

   // Leap flag and period lengths derived from the running year counters
   always_comb begin
      leap        = ((mod4 == 2'd0) && (mod100 != 7'd0)) || (mod400 == 9'd0);
      yearLen     = leap ? 9'd366 : 9'd365;
      curMonthLen = monthLen(monthReg, leap);
      wdSum       = {1'b0, divRem[2:0]} + 4'(EPOCH_WEEKDAY);
   end

   // State register
   always_ff @(posedge clockSignal) begin
      if (reset) state <= ST_IDLE;
      else       state <= nextState;
   end

   // Next state, divider operand selection and handshake outputs
   always_comb begin
      nextState   = state;
      divStart    = 1'b0;
      divDividend = tickReg;
      divDivisor  = CS_DIVISOR;
      busy        = (state != ST_IDLE) && (state != ST_DONE);
      done        = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            if (convertStart) nextState = ST_DIV_CS;
         end
         ST_DIV_CS: begin
            divStart = !divIssued;
            if (divIssued && divDone) nextState = ST_DIV_DAY;
         end
         ST_DIV_DAY: begin
            divDividend = secsReg;
            divDivisor  = DAY_DIVISOR;
            divStart    = !divIssued;
            if (divIssued && divDone) nextState = ST_RANGE;
         end
         ST_RANGE: begin
            nextState = (dayReg > DAY_LIMIT) ? ST_DONE : ST_DIV_WK;
         end
         ST_DIV_WK: begin
            divDividend = dayReg;
            divDivisor  = WK_DIVISOR;
            divStart    = !divIssued;
            if (divIssued && divDone) nextState = ST_HMS;
         end
         ST_HMS: begin
            if (secOfDay < 17'd60) nextState = ST_YEAR;
         end
         ST_YEAR: begin
            if (dayReg < 64'(yearLen)) nextState = ST_MONTH;
         end
         ST_MONTH: begin
            if (dayReg < 64'(curMonthLen)) nextState = ST_DONE;
         end
         ST_DONE: begin
            nextState = convertStart ? ST_DIV_CS : ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   // Working registers and the held output fields, written only when a conversion completes
   always_ff @(posedge clockSignal) begin
      if (reset) begin
         tickReg      <= 64'd0;
         secsReg      <= 64'd0;
         dayReg       <= 64'd0;
         secOfDay     <= 17'd0;
         csReg        <= 7'd0;
         hourReg      <= 5'd0;
         minReg       <= 6'd0;
         yearReg      <= 14'(EPOCH_YEAR);
         mod4         <= 2'd2;
         mod100       <= 7'd70;
         mod400       <= 9'd370;
         monthReg     <= 4'd1;
         wdReg        <= 3'(EPOCH_WEEKDAY);
         divIssued    <= 1'b0;
         overflow     <= 1'b0;
         centiseconds <= 7'd0;
         seconds      <= 6'd0;
         minutes      <= 6'd0;
         hours        <= 5'd0;
         dayOfMonth   <= 5'd1;
         month        <= 4'd1;
         year         <= 14'(EPOCH_YEAR);
         weekday      <= 3'(EPOCH_WEEKDAY);
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (convertStart) begin
                  tickReg   <= tickCount;
                  divIssued <= 1'b0;
               end
            end
            ST_DIV_CS: begin
               if (!divIssued) divIssued <= 1'b1;
               else if (divDone) begin
                  csReg     <= divRem[6:0];
                  secsReg   <= divQuot;
                  divIssued <= 1'b0;
               end
            end
            ST_DIV_DAY: begin
               if (!divIssued) divIssued <= 1'b1;
               else if (divDone) begin
                  dayReg    <= divQuot;
                  secOfDay  <= divRem;
                  divIssued <= 1'b0;
               end
            end
            ST_RANGE: begin
               if (dayReg > DAY_LIMIT) begin
                  overflow     <= 1'b1;
                  centiseconds <= 7'(TICKS_PER_SEC - 1);
                  seconds      <= 6'd59;
                  minutes      <= 6'd59;
                  hours        <= 5'd23;
                  dayOfMonth   <= 5'd31;
                  month        <= 4'd12;
                  year         <= 14'(MAX_YEAR);
                  weekday      <= 3'd5;
               end else begin
                  hourReg  <= 5'd0;
                  minReg   <= 6'd0;
                  yearReg  <= 14'(EPOCH_YEAR);
                  mod4     <= 2'd2;
                  mod100   <= 7'd70;
                  mod400   <= 9'd370;
                  monthReg <= 4'd1;
               end
            end
            ST_DIV_WK: begin
               if (!divIssued) divIssued <= 1'b1;
               else if (divDone) begin
                  wdReg     <= (wdSum >= 4'd7) ? 3'(wdSum - 4'd7) : wdSum[2:0];
                  divIssued <= 1'b0;
               end
            end
            ST_HMS: begin
               if (secOfDay >= 17'd3600) begin
                  secOfDay <= secOfDay - 17'd3600;
                  hourReg  <= hourReg + 5'd1;
               end else if (secOfDay >= 17'd60) begin
                  secOfDay <= secOfDay - 17'd60;
                  minReg   <= minReg + 6'd1;
               end
            end
            ST_YEAR: begin
               if (dayReg >= 64'(yearLen)) begin
                  dayReg  <= dayReg - 64'(yearLen);
                  yearReg <= yearReg + 14'd1;
                  mod4    <= mod4 + 2'd1;
                  mod100  <= (mod100 == 7'd99) ? 7'd0 : mod100 + 7'd1;
                  mod400  <= (mod400 == 9'd399) ? 9'd0 : mod400 + 9'd1;
               end
            end
            ST_MONTH: begin
               if (dayReg >= 64'(curMonthLen)) begin
                  dayReg   <= dayReg - 64'(curMonthLen);
                  monthReg <= monthReg + 4'd1;
               end else begin
                  overflow     <= 1'b0;
                  centiseconds <= csReg;
                  seconds      <= secOfDay[5:0];
                  minutes      <= minReg;
                  hours        <= hourReg;
                  dayOfMonth   <= dayReg[4:0] + 5'd1;
                  month        <= monthReg;
                  year         <= yearReg;
                  weekday      <= wdReg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_to_calendar.sv
// tb/tb_tick_to_calendar.sv - scoreboard testbench for tick_to_calendar
module tb_tick_to_calendar;

   logic        clockSignal = 1'b0;
   logic        reset;
   logic [63:0] tickCount;
   logic        convertStart;
   logic        busy, done, overflow;
   logic [6:0]  centiseconds;
   logic [5:0]  seconds, minutes;
   logic [4:0]  hours, dayOfMonth;
   logic [3:0]  month;
   logic [13:0] year;
   logic [2:0]  weekday;

   tick_to_calendar #(.TICKS_PER_SEC(100), .MAX_YEAR(9999)) dut (
      .clockSignal  (clockSignal),
      .reset        (reset),
      .tickCount    (tickCount),
      .convertStart (convertStart),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .centiseconds (centiseconds),
      .seconds      (seconds),
      .minutes      (minutes),
      .hours        (hours),
      .dayOfMonth   (dayOfMonth),
      .month        (month),
      .year         (year),
      .weekday      (weekday)
   );

   always #5 clockSignal = ~clockSignal;

   typedef struct {
      int ovf, yr, mon, dom, hr, mi, sec, cs, wd;
   } expT;

   expT expQ[$];
   int  checks    = 0;
   int  errors    = 0;
   int  doneCount = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic expT mk(input int ovf, input int yr, input int mon, input int dom,
                              input int hr, input int mi, input int sec, input int cs, input int wd);
      expT e;
      e.ovf = ovf; e.yr = yr; e.mon = mon; e.dom = dom;
      e.hr = hr; e.mi = mi; e.sec = sec; e.cs = cs; e.wd = wd;
      return e;
   endfunction

   task automatic checkFields(input string tag, input expT e);
      check({tag, "_overflow"}, overflow, e.ovf);
      check({tag, "_year"}, year, e.yr);
      check({tag, "_month"}, month, e.mon);
      check({tag, "_day"}, dayOfMonth, e.dom);
      check({tag, "_hours"}, hours, e.hr);
      check({tag, "_minutes"}, minutes, e.mi);
      check({tag, "_seconds"}, seconds, e.sec);
      check({tag, "_centis"}, centiseconds, e.cs);
      check({tag, "_weekday"}, weekday, e.wd);
   endtask

   // Monitor: every done pulse is matched against the oldest expected result
   always @(negedge clockSignal) begin
      expT e;
      if (!reset && done) begin
         doneCount++;
         check("busy_low_at_done", busy, 0);
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual=done with empty scoreboard required=no done");
         end else begin
            e = expQ.pop_front();
            checkFields("conv", e);
         end
      end
   end

   task automatic pulseStart(input logic [63:0] t);
      @(posedge clockSignal); #1;
      tickCount    = t;
      convertStart = 1'b1;
      @(posedge clockSignal); #1;
      convertStart = 1'b0;
   endtask

   task automatic issue(input logic [63:0] t, input expT e);
      expQ.push_back(e);
      pulseStart(t);
      check("busy_after_start", busy, 1);
   endtask

   task automatic waitDone(input string name);
      int  c0  = doneCount;
      bit  got = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(posedge clockSignal);
         if (doneCount != c0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: actual=no done within 12000 cycles required=done", name);
      end
   endtask

   initial begin
      expT epoch, day2, leap2000, y2100, sat;
      int  cnt0;
      epoch    = mk(0, 1970, 1, 1, 0, 0, 0, 0, 4);
      day2     = mk(0, 1970, 1, 2, 0, 0, 0, 0, 5);
      leap2000 = mk(0, 2000, 2, 29, 12, 34, 56, 78, 2);
      y2100    = mk(0, 2100, 3, 1, 0, 0, 0, 0, 1);
      sat      = mk(1, 9999, 12, 31, 23, 59, 59, 99, 5);

      reset        = 1'b1;
      convertStart = 1'b0;
      tickCount    = 64'd0;
      repeat (3) @(posedge clockSignal);
      #1 reset = 1'b0;
      @(negedge clockSignal);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      checkFields("reset", epoch);

      issue(64'd0, epoch);
      waitDone("epoch");
      issue(64'd8640000, day2);
      waitDone("day2");
      issue(64'hFFFF_FFFF_FFFF_FFFF, sat);
      waitDone("saturate");
      issue(64'd95182769678, leap2000);
      waitDone("leap2000");
      issue(64'd410754240000, y2100);
      waitDone("y2100");

      // Start held high while busy: ignored until the done cycle, then accepted there
      issue(64'd0, epoch);
      expQ.push_back(y2100);
      tickCount    = 64'd410754240000;
      convertStart = 1'b1;
      waitDone("b2b_first");
      #1 convertStart = 1'b0;
      check("busy_after_done_cycle_start", busy, 1);
      waitDone("b2b_second");
      repeat (300) @(posedge clockSignal);

      // Second start while busy, then reset mid-run aborts without a done pulse
      pulseStart(64'd8640000);
      pulseStart(64'd0);
      repeat (30) @(posedge clockSignal);
      #1 reset = 1'b1;
      repeat (2) @(posedge clockSignal);
      #1 reset = 1'b0;
      cnt0 = doneCount;
      @(negedge clockSignal);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      checkFields("abort", epoch);
      repeat (400) @(posedge clockSignal);
      check("abort_no_done", doneCount, cnt0);
      check("scoreboard_empty", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tick_to_calendar.md
Name: tick_to_calendar

Overview:
- Downstream stage of the timer/clock core. It converts the free-running 64-bit 100 Hz tick count (ticks since 1970-01-01 00:00:00.00 UTC) into time-of-day, calendar date and weekday fields for the display.
- It is a multi-cycle iterative converter with a start/busy/done handshake.
- Outputs hold the last completed conversion, so the display never sees partial results.

Parameters:
- TICKS_PER_SEC, 100, tick rate of tickCount.
- MAX_YEAR, 9999, last representable year; beyond it, outputs saturate.

Ports:
- clockSignal  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tickCount  in  64  ticks since epoch; sampled on an accepted convertStart
- convertStart  in  1  request; accepted only when busy=0
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when the outputs update
- overflow  out  1  last input exceeded MAX_YEAR-12-31 23:59:59.99
- centiseconds  out  7  0..99
- seconds  out  6  0..59
- minutes  out  6  0..59
- hours  out  5  0..23
- dayOfMonth  out  5  1..31
- month  out  4  1..12
- year  out  14  1970..MAX_YEAR
- weekday  out  3  0=Sunday..6=Saturday

Behaviour:
- Reset outputs: busy=0, done=0, overflow=0, fields = 1970-01-01 00:00:00.00, weekday=4 (Thursday). Reset during a conversion aborts it and forces these values.
- Handshake:
  - In IDLE, convertStart=1 latches tickCount, sets busy=1 the next cycle and enters DIV_CS.
  - convertStart while busy is ignored, not queued.
  - On completion: done=1 for exactly one cycle, all output fields update in that same cycle, and busy=0 in that cycle.
  - A new convertStart is accepted in the cycle done is high.
- States and transitions:
  - DIV_CS: tick / TICKS_PER_SEC, using the shared divider. The remainder gives centiseconds; the quotient is totalSecs.
  - DIV_DAY: totalSecs / 86400. The quotient is days; the remainder is secOfDay (17 bits).
  - RANGE: if days > 2932896, go to DONE with overflow=1 and outputs = 9999-12-31 23:59:59.99, weekday=5 (Friday). Otherwise go to DIV_WK.
  - DIV_WK: days / 7, then weekday = (rem + 4) mod 7.
  - HMS: subtract 3600 per cycle while secOfDay ≥ 3600, incrementing hours. Then subtract 60 per cycle, incrementing minutes. The residue is seconds.
  - YEAR: start at year 1970 with mod4=2, mod100=70, mod400=370.
    - Each cycle, yearLen = 366 if leap, else 365.
    - If days ≥ yearLen: subtract it, increment year, and advance all three mod counters, each wrapping.
    - Otherwise go to MONTH.
  - Leap rule: (mod4==0 && mod100!=0) || mod400==0.
  - MONTH: start at month 1. Each cycle, if days ≥ monthLen(month, leap), subtract and increment month; otherwise dayOfMonth = days+1 and go to DONE.
  - DONE: one cycle, then IDLE.
- Divider:
  - Restoring shift-subtract, 64-bit dividend, exactly 64 cycles per divide.
  - Divisor widths: 7 bits for /100, 17 bits for /86400, 3 bits for /7. Zero-extend the divisor.
- Latency: at most about 3×66 + 23 + 59 + 8030 + 12 + 4 cycles. It is data-dependent; the bench must not assume a fixed latency.

Decomposition:
- Shared package (calendar_pkg):
  - Constants: EPOCH_YEAR=1970, EPOCH_WEEKDAY=4, SECS_PER_DAY=86400, MAX_DAYS=2932896.
  - State enum for the FSM.
  - Month-length function taking (month, leap).
- Sub-module: seq_divider (64-bit dividend, 17-bit divisor, start/done, quotient/remainder). It is instantiated once and reused for all three divides.

Test Plan:
- Reset, then tickCount=0 with start -> done pulse, 1970-01-01 00:00:00.00, weekday=4, overflow=0.
- tickCount=8640000 -> 1970-01-02 00:00:00.00, weekday=5.
- tickCount=95182769678 -> 2000-02-29 12:34:56.78, weekday=2 (leap year, divisible by 400).
- tickCount=410754240000 -> 2100-03-01 00:00:00.00, weekday=1 (century year, not leap).
- tickCount=64'hFFFF_FFFF_FFFF_FFFF -> overflow=1, 9999-12-31 23:59:59.99, weekday=5.
- Start tickCount=8640000, pulse start again with 0 while busy, then reset mid-run -> second start ignored; after reset, outputs are the epoch values, busy=0, and no done pulse.
